// File: rtl/pmp_dmp.sv
// pmp_dmp: combinational PMP checker with domain memory protection.
// Finds the lowest-index PMP entry matching the address, grants the access
// only if the entry's R/W/X rights and its DMP domain both permit it, and
// provides a registered copy of the verdict for pipelined consumers.
module pmp_dmp #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [PLEN-1:0]                       addr_i,
    input  logic [2:0]                            access_type_i,
    input  logic [1:0]                            priv_lvl_i,
    input  logic [1:0]                            curdom_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_i,
    input  logic [NR_ENTRIES-1:0][7:0]            pmpconf_i,
    input  logic [NR_ENTRIES-1:0][1:0]            dmpconf_i,
    output logic                                  allow_o,
    output logic                                  allow_q_o
);

    // addr_mode encoding of pmpcfg[4:3]
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_TOR   = 2'd1;
    localparam logic [1:0] MODE_NA4   = 2'd2;
    localparam logic [1:0] MODE_NAPOT = 2'd3;

    localparam logic [1:0] PRIV_M = 2'd3;
    localparam logic [1:0] DOMI   = 2'd3;

    // Word address compared against the entry registers.
    logic [PMP_LEN-1:0]    a;
    // High when no address bit above the comparable range is set.
    logic                  upper_zero;
    logic [NR_ENTRIES-1:0] match;
    logic [NR_ENTRIES-1:0] entry_allow;
    logic                  allow_d;
    logic                  allow_q;

    assign a = addr_i[PMP_LEN+1:2];

    // Addresses beyond the reach of the pmpaddr registers never match.
    if (PLEN > PMP_LEN + 2) begin : g_upper
        assign upper_zero = ~|addr_i[PLEN-1:PMP_LEN+2];
    end else begin : g_no_upper
        assign upper_zero = 1'b1;
    end

    // Byte offset bits and reserved pmpcfg bits play no part in the check.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr_i[1:0], pmpconf_i};

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
        logic [PMP_LEN-1:0] lower;
        logic [PMP_LEN-1:0] napot_mask;
        logic [1:0]         mode;
        logic               locked;
        logic [2:0]         rights;
        logic               perm_ok;
        logic               dom_ok;

        assign mode   = pmpconf_i[i][4:3];
        assign locked = pmpconf_i[i][7];
        assign rights = pmpconf_i[i][2:0];

        // TOR lower bound is the previous entry's address, zero for entry 0.
        if (i == 0) begin : g_first
            assign lower = '0;
        end else begin : g_rest
            assign lower = conf_addr_i[i-1];
        end

        // Trailing ones plus the first zero are don't-care bits; all-ones
        // conf_addr yields an all-zero mask and matches everything.
        assign napot_mask = ~(conf_addr_i[i] ^ (conf_addr_i[i] + PMP_LEN'(1)));

        assign match[i] = upper_zero && (
            ((mode == MODE_TOR)   && (lower <= a) && (a < conf_addr_i[i])) ||
            ((mode == MODE_NA4)   && (a == conf_addr_i[i])) ||
            ((mode == MODE_NAPOT) && ((a & napot_mask) == (conf_addr_i[i] & napot_mask))) ||
            ((mode == MODE_OFF)   && 1'b0));

        // Unlocked entries do not restrict M-mode; locked ones always apply.
        assign perm_ok = ((priv_lvl_i == PRIV_M) && !locked) ||
                         ((access_type_i & rights) == access_type_i);

        // DOMI on either side is compatible with every domain.
        assign dom_ok = (curdom_i == DOMI) || (dmpconf_i[i] == DOMI) ||
                        (curdom_i == dmpconf_i[i]);

        assign entry_allow[i] = perm_ok && dom_ok;
    end

    // Priority select: scanning downward lets the lowest matching index win;
    // with no match only M-mode is granted and the domain is not checked.
    always_comb begin
        allow_d = (priv_lvl_i == PRIV_M);
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                allow_d = entry_allow[i];
            end
        end
    end

    assign allow_o = allow_d;

    // Registered verdict; reset forces deny.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            allow_q <= 1'b0;
        end else begin
            allow_q <= allow_d;
        end
    end

    assign allow_q_o = allow_q;

endmodule

// File: tb/tb_pmp_dmp.sv
// Bench for pmp_dmp: directed vectors, expected verdicts queued by the
// driver and checked at the falling edge by an independent monitor.
module tb_pmp_dmp;

    localparam int PLEN    = 16;
    localparam int PMP_LEN = 13;

    // Output selectors for the monitor.
    localparam int SEL_C1 = 0;  // single-entry allow_o
    localparam int SEL_Q1 = 1;  // single-entry allow_q_o
    localparam int SEL_C2 = 2;  // two-entry allow_o

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [PLEN-1:0]          addr;
    logic [2:0]               acc;
    logic [1:0]               priv;
    logic [1:0]               curdom;
    logic [0:0][PMP_LEN-1:0]  conf1;
    logic [0:0][7:0]          pcfg1;
    logic [0:0][1:0]          dcfg1;
    logic [1:0][PMP_LEN-1:0]  conf2;
    logic [1:0][7:0]          pcfg2;
    logic [1:0][1:0]          dcfg2;
    logic                     allow1, allow_q1, allow2, allow_q2;

    pmp_dmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .addr_i(addr), .access_type_i(acc),
        .priv_lvl_i(priv), .curdom_i(curdom), .conf_addr_i(conf1),
        .pmpconf_i(pcfg1), .dmpconf_i(dcfg1), .allow_o(allow1), .allow_q_o(allow_q1));

    pmp_dmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .addr_i(addr), .access_type_i(acc),
        .priv_lvl_i(priv), .curdom_i(curdom), .conf_addr_i(conf2),
        .pmpconf_i(pcfg2), .dmpconf_i(dcfg2), .allow_o(allow2), .allow_q_o(allow_q2));

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int         sel_q[$];
    string      name_q[$];
    logic       vld = 1'b0;
    int         tests = 0;
    int         fails = 0;

    localparam logic [2:0] READ = 3'b001, WRITE = 3'b010, EXEC = 3'b100;
    localparam logic [1:0] PU = 2'd0, PM = 2'd3;
    localparam logic [7:0] NAPOT_RWX = 8'h1F, NAPOT_X = 8'h1C, NAPOT_R = 8'h19;
    localparam logic [7:0] NAPOT_X_L = 8'h9C, NA4_X = 8'h14, TOR_RWX = 8'h0F;
    localparam logic [PMP_LEN-1:0] REGION = PMP_LEN'(13'h065F);  // 0x1900..0x19FF

    // Monitor: whenever a vector is presented, pop and compare.
    always @(negedge clk) begin
        if (vld) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: output presented with empty expected queue");
            end else begin
                logic [0:0] e;
                int         s;
                string      n;
                logic       act;
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                n = name_q.pop_front();
                act = (s == SEL_C1) ? allow1 : (s == SEL_Q1) ? allow_q1 : allow2;
                tests++;
                if (act !== e[0]) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b (addr=%h acc=%b priv=%0d cur=%0d)",
                             n, act, e[0], addr, acc, priv, curdom);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_out(input int sel, input logic e, input string name);
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(name);
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
    endtask

    task automatic set_req(input logic [PLEN-1:0] a, input logic [2:0] t,
                           input logic [1:0] p, input logic [1:0] d);
        addr = a; acc = t; priv = p; curdom = d;
    endtask

    // Expected verdict for RWX entry, bit index curdom*4 + dmp domain.
    logic [15:0] rwx_tab;

    initial begin
        rwx_tab = 16'hFCA9;
        set_req(16'h19BA, READ, PU, 2'd0);
        conf1[0] = REGION; pcfg1[0] = NAPOT_RWX; dcfg1[0] = 2'd0;
        conf2 = '0; pcfg2 = '0; dcfg2 = '0;

        // Reset held two cycles: registered verdict must be deny.
        repeat (2) @(posedge clk);
        #1;
        expect_out(SEL_Q1, 1'b0, "q_in_reset");

        // Release reset with an allowed access: one edge later q follows.
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        expect_out(SEL_Q1, 1'b1, "q_after_release");
        // Re-assert reset: combinational verdict unaffected, q clears.
        rst_ni = 1'b0;
        expect_out(SEL_C1, 1'b1, "comb_during_reset");
        expect_out(SEL_Q1, 1'b0, "q_reasserted");
        rst_ni = 1'b1;

        // Domain matrix with full rights, then with exec-only rights.
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 4; d++) begin
                set_req(16'h19BA, READ, PU, 2'(c));
                pcfg1[0] = NAPOT_RWX; dcfg1[0] = 2'(d);
                #1 expect_out(SEL_C1, rwx_tab[c*4+d], $sformatf("rwx_cur%0d_dmp%0d", c, d));
                pcfg1[0] = NAPOT_X;
                #1 expect_out(SEL_C1, 1'b0, $sformatf("xonly_cur%0d_dmp%0d", c, d));
            end
        end

        // Boundary: just past the region, U denied, M granted.
        pcfg1[0] = NAPOT_RWX; dcfg1[0] = 2'd0;
        set_req(16'h1A00, READ, PU, 2'd0);
        #1 expect_out(SEL_C1, 1'b0, "nomatch_u");
        set_req(16'h1A00, READ, PM, 2'd0);
        #1 expect_out(SEL_C1, 1'b1, "nomatch_m");
        // Last word of region and first word.
        set_req(16'h19FC, WRITE, PU, 2'd0);
        #1 expect_out(SEL_C1, 1'b1, "region_top");
        set_req(16'h18FC, READ, PU, 2'd0);
        #1 expect_out(SEL_C1, 1'b0, "below_region");
        // Address bit above the comparable range set: no match.
        set_req(16'h99BA, READ, PU, 2'd0);
        #1 expect_out(SEL_C1, 1'b0, "upper_bit_set");
        // Write to read-only entry.
        pcfg1[0] = NAPOT_R;
        set_req(16'h19BA, WRITE, PU, 2'd0);
        #1 expect_out(SEL_C1, 1'b0, "write_ro");
        // M-mode: unlocked entry passes rights but still checks domain.
        pcfg1[0] = NAPOT_X;
        set_req(16'h19BA, READ, PM, 2'd0);
        #1 expect_out(SEL_C1, 1'b1, "m_unlocked");
        dcfg1[0] = 2'd1;
        #1 expect_out(SEL_C1, 1'b0, "m_unlocked_domain");
        dcfg1[0] = 2'd0; pcfg1[0] = NAPOT_X_L;
        #1 expect_out(SEL_C1, 1'b0, "m_locked");
        // Whole-space NAPOT.
        pcfg1[0] = NAPOT_RWX; conf1[0] = '1;
        set_req(16'h0004, EXEC, PU, 2'd2);
        #1 expect_out(SEL_C1, 1'b0, "napot_all_dom");
        dcfg1[0] = 2'd2;
        #1 expect_out(SEL_C1, 1'b1, "napot_all");

        // Priority: NA4 exec-only entry 0 shadows RWX entry 1.
        conf2[0] = PMP_LEN'(13'h066E); pcfg2[0] = NA4_X;
        conf2[1] = REGION;            pcfg2[1] = NAPOT_RWX;
        set_req(16'h19BA, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b0, "prio_entry0");
        set_req(16'h19BC, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b1, "prio_entry1");
        // TOR entry 1 between 0x1900 and 0x19B8 (exclusive), entry 0 OFF.
        conf2[0] = PMP_LEN'(13'h0640); pcfg2[0] = 8'h07;
        conf2[1] = PMP_LEN'(13'h066E); pcfg2[1] = TOR_RWX;
        set_req(16'h19B4, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b1, "tor_inside");
        set_req(16'h1900, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b1, "tor_lower");
        set_req(16'h19B8, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b0, "tor_upper_excl");
        set_req(16'h18FC, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b0, "tor_below");
        // Empty TOR range never matches.
        conf2[0] = PMP_LEN'(13'h0670);
        set_req(16'h19B4, READ, PU, 2'd0);
        #1 expect_out(SEL_C2, 1'b0, "tor_empty");

        // Drain with a bound.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: %0d expected entries left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pmp_dmp.md
# pmp_dmp

Combinational physical-memory-protection checker extended with domain memory protection (DMP), used by the CVA6 load/store and fetch paths. For one physical address and access type it finds the highest-priority matching PMP entry. It grants the access only if that entry's R/W/X rights cover the request and the entry's DMP domain is compatible with the current execution domain. A registered copy of the verdict is provided for pipelined consumers.

## Interface
Parameters:
- PLEN, 56: physical address width in bits.
- PMP_LEN, 54: width of each entry address register, which holds address bits [PMP_LEN+1:2].
- NR_ENTRIES, 4: number of PMP/DMP entries, 1..16.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: reset, synchronous, active-low.
- addr_i in PLEN: physical address being checked.
- access_type_i in 3: riscv::pmp_access_t one-hot request. READ=3'b001, WRITE=3'b010, EXEC=3'b100.
- priv_lvl_i in 2: riscv::priv_lvl_t. U=0, S=1, M=3.
- curdom_i in 2: riscv::dmp_domain_t current domain. DOM0=0, DOM1=1, DOM2=2, DOMI=3.
- conf_addr_i in NR_ENTRIES×PMP_LEN: per-entry pmpaddr.
- pmpconf_i in NR_ENTRIES×8: riscv::pmpcfg_t, one per entry. Fields from MSB: locked[7], reserved[6:5], addr_mode[4:3], access_type[2:0] as an R/W/X mask. addr_mode encoding: OFF=0, TOR=1, NA4=2, NAPOT=3.
- dmpconf_i in NR_ENTRIES×2: riscv::dmpcfg_t. The domain field uses the same encoding as curdom_i.
- allow_o out 1: combinational verdict; 1 means the access is granted.
- allow_q_o out 1: allow_o registered on clk_i.

## Operation
- Address comparison uses a = addr_i[PMP_LEN+1:2]. addr_i bits [1:0] are ignored, and bits above PMP_LEN+1 must be zero to match.
- Per-entry match rule, by addr_mode:
  - OFF: never matches.
  - TOR: matches if conf_addr[i-1] ≤ a < conf_addr[i]. For entry 0 the lower bound is 0. If lower ≥ upper, the entry never matches.
  - NA4: matches if a == conf_addr[i].
  - NAPOT: let k = number of trailing ones in conf_addr[i]. Matches if a and conf_addr[i] agree on all bits above bit k. The region size is 2^(k+3) bytes. If all bits are ones, the whole space matches.
- Priority: the lowest-index matching entry decides. Higher entries are ignored.
- PMP rights for matching entry i:
  - perm_ok = ((access_type_i & cfg.access_type) == access_type_i).
  - In M-mode, an unlocked entry gives perm_ok = 1. A locked entry is checked normally.
- DMP rights for matching entry i:
  - dom_ok = (curdom_i == DOMI) || (dmp.domain == DOMI) || (curdom_i == dmp.domain).
  - This applies at every privilege level.
- Matched-entry verdict: allow_o = perm_ok && dom_ok.
- No matching entry:
  - allow_o = 1 when priv_lvl_i == M.
  - allow_o = 0 for U or S.
  - The DMP check does not apply.
- Reserved bits of pmpcfg are ignored.

## Timing
- allow_o is purely combinational, with zero-cycle latency from any input. There is no handshake.
- allow_q_o:
  - On each rising clk_i: allow_q_o <= allow_o, one-cycle latency.
  - While rst_ni == 0 at a rising edge, allow_q_o <= 0. Its reset value is 0 (deny).
  - Reset asserted mid-operation forces allow_q_o to 0 at the next edge. allow_o is unaffected by reset.
- Configuration changes take effect on allow_o immediately, with no caching.

## Test plan
Common setup: NR_ENTRIES=1, PLEN=16, PMP_LEN=13, priv=U, addr=16'h19BA, READ. Entry 0 is NAPOT with conf_addr=(16'h1900+16'h7F)>>2, a 256 B region at 16'h1900–16'h19FF.

- cfg R|W|X:
  - curdom DOM0 with dmp DOM0 or DOMI -> allow=1.
  - curdom DOM0 with dmp DOM1 or DOM2 -> allow=0.
- cfg R|W|X:
  - curdom DOM1 with dmp DOM1 or DOMI -> 1.
  - curdom DOM1 with dmp DOM0 or DOM2 -> 0.
- cfg R|W|X, curdom DOMI, dmp any of DOM0/1/2/I -> 1.
- cfg EXEC only -> allow=0 for all 12 curdom×dmp combinations.
- Boundary and priority:
  - addr=16'h1A00 -> 0, since U-mode with no match is denied.
  - The same address with priv=M -> 1.
  - NR_ENTRIES=2, entry 0 NA4 at 16'h19B8 with X only, entry 1 the NAPOT R|W|X region above: addr 16'h19BA READ -> 0, because entry 0 wins.
- Register path:
  - Hold rst_ni=0 for 2 cycles -> allow_q_o=0.
  - Release reset with a matching allowed access -> allow_q_o=1 one edge later.
  - Assert rst_ni=0 again -> allow_q_o=0 at the next edge.
